// File: rtl/mempool_pkg.sv
// mempool_pkg: shared TCDM types for the MemPool core-side memory path
// Holds address/data widths, the AMO opcode enum, the reorder id, the
// id-tagged interconnect payload and the reorder-buffer slot record.
package mempool_pkg;
  localparam int unsigned AddrWidth      = 32;
  localparam int unsigned DataWidth      = 32;
  localparam int unsigned BeWidth        = DataWidth / 8;
  localparam int unsigned ReorderIdWidth = 4;
  typedef logic [AddrWidth-1:0]      addr_t;
  typedef logic [DataWidth-1:0]      data_t;
  typedef logic [BeWidth-1:0]        be_t;
  typedef logic [ReorderIdWidth-1:0] reorder_id_t;
  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_t;
  typedef struct packed {
    reorder_id_t id;
    amo_t        amo;
    data_t       data;
  } tcdm_payload_t;
  typedef struct packed {
    logic  arrived;
    data_t data;
  } rob_slot_t;
endpackage

// File: rtl/tcdm_rsp_reorder.sv
// tcdm_rsp_reorder: per-core TCDM id tagging and in-order response return
// Ports: clk_i/rst_i (async, active-high); req_* core request in;
// tcdm_req_* tagged request out; tcdm_rsp_* out-of-order responses in
// (never back-pressured); rsp_* in-order responses back to the core.
module tcdm_rsp_reorder
  import mempool_pkg::*;
#(
  parameter int unsigned NumOutstanding = 8,
  parameter int unsigned IdxWidth       = $clog2(NumOutstanding)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  addr_t         req_addr_i,
  input  logic          req_wen_i,
  input  be_t           req_be_i,
  input  amo_t          req_amo_i,
  input  data_t         req_data_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output data_t         rsp_data_o,
  output logic          tcdm_req_valid_o,
  input  logic          tcdm_req_ready_i,
  output addr_t         tcdm_req_addr_o,
  output logic          tcdm_req_wen_o,
  output be_t           tcdm_req_be_o,
  output tcdm_payload_t tcdm_req_payload_o,
  input  logic          tcdm_rsp_valid_i,
  input  tcdm_payload_t tcdm_rsp_payload_i
);
  localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);
  if (NumOutstanding > 2 ** ReorderIdWidth || NumOutstanding < 2 ||
      (NumOutstanding & (NumOutstanding - 1)) != 0) begin : g_bad_param
    $error("tcdm_rsp_reorder: NumOutstanding must be a power of two in [2, 2**ReorderIdWidth]");
  end
  rob_slot_t             slot_q [NumOutstanding];
  logic [IdxWidth-1:0]   head_q, tail_q, rsp_idx, rsp_off;
  logic [CntWidth-1:0]   cnt_q;
  logic                  full, alloc, retire, id_hi_ok, outstanding, capture;
  logic                  unused;
  assign full     = cnt_q == CntWidth'(NumOutstanding);
  assign alloc    = tcdm_req_valid_o & tcdm_req_ready_i;
  assign retire   = rsp_valid_o & rsp_ready_i;
  assign rsp_idx  = tcdm_rsp_payload_i.id[IdxWidth-1:0];
  assign id_hi_ok = (tcdm_rsp_payload_i.id >> IdxWidth) == '0;
  // An id is outstanding when its distance from head lies inside the live window.
  assign rsp_off     = rsp_idx - head_q;
  assign outstanding = CntWidth'(rsp_off) < cnt_q;
  // Illegal responses are dropped so state stays consistent.
  assign capture  = tcdm_rsp_valid_i & id_hi_ok & outstanding & ~slot_q[rsp_idx].arrived;
  assign unused   = ^tcdm_rsp_payload_i.amo;
  assign tcdm_req_valid_o   = req_valid_i & ~full;
  assign req_ready_o        = tcdm_req_ready_i & ~full;
  assign tcdm_req_addr_o    = req_addr_i;
  assign tcdm_req_wen_o     = req_wen_i;
  assign tcdm_req_be_o      = req_be_i;
  assign tcdm_req_payload_o = '{id: reorder_id_t'(tail_q), amo: req_amo_i, data: req_data_i};
  assign rsp_valid_o = slot_q[head_q].arrived;
  assign rsp_data_o  = rsp_valid_o ? slot_q[head_q].data : '0;
  // Retire and capture never target the same slot: retire needs arrived=1, capture arrived=0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NumOutstanding; i++) slot_q[i] <= '0;
    end else begin
      if (alloc) tail_q <= tail_q + IdxWidth'(1);
      if (retire) begin
        head_q                 <= head_q + IdxWidth'(1);
        slot_q[head_q].arrived <= 1'b0;
      end
      if (capture) slot_q[rsp_idx] <= '{arrived: 1'b1, data: tcdm_rsp_payload_i.data};
      cnt_q <= cnt_q + CntWidth'(alloc) - CntWidth'(retire);
    end
  end
  a_id_hi : assert property (@(posedge clk_i) disable iff (rst_i)
    tcdm_rsp_valid_i |-> id_hi_ok);
  a_outstanding : assert property (@(posedge clk_i) disable iff (rst_i)
    tcdm_rsp_valid_i |-> outstanding);
  a_dup : assert property (@(posedge clk_i) disable iff (rst_i)
    tcdm_rsp_valid_i |-> !slot_q[rsp_idx].arrived);
endmodule
